traffic_light_ctrl: RTL and testbench

Two-road traffic-light sequencer driven by the one-second toggle produced by the upstream clock divider. Runs entirely in the fast `clkin` domain: it edge-detects the divider output into a one-cycle tick, steps a phase state machine with per-phase countdowns, and drives both roads' lamps plus a two-digit BCD remaining-time value for the seven-segment display stage. Night (flashing yellow) and emergency (all red) overrides are included.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/bin2bcd_99.sv | 7 +
 rtl/traffic_light_ctrl.sv | 75 +++++++
 tb/tb_traffic_light_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: state encodings and lamp constants shared by the traffic-light controller and its display stage
package traffic_pkg;
  typedef enum logic [2:0] {
    S_MG     = 3'd0,
    S_MY     = 3'd1,
    S_SG     = 3'd2,
    S_SY     = 3'd3,
    S_NIGHT  = 3'd4,
    S_ALLRED = 3'd5
  } state_e;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
endpackage

// File: rtl/bin2bcd_99.sv
// bin2bcd_99: combinational 0..99 binary to two-digit BCD; in bin[6:0], out bcd[7:0]={tens,units}
module bin2bcd_99 (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);
  assign bcd = {4'(bin / 7'd10), 4'(bin % 7'd10)};
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road light sequencer; in clkin, rst_N, tick_in, night_mode, emergency; out main_lamp, side_lamp, count_bcd, phase
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter logic [6:0] GREEN_MAIN = 7'd25,
  parameter logic [6:0] GREEN_SIDE = 7'd15,
  parameter logic [6:0] YELLOW     = 7'd3
) (
  input  logic       clkin,
  input  logic       rst_N,
  input  logic       tick_in,
  input  logic       night_mode,
  input  logic       emergency,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic [7:0] count_bcd,
  output logic [2:0] phase
);
  state_e     state_q, state_d, nxt;
  logic [6:0] cnt_q, cnt_d;
  logic       flash_q, flash_d;
  logic       tick_d_q;
  logic       tick;
  logic [1:0] seq_nx;
  function automatic logic [6:0] dur(input state_e s);
    return (s == S_MY || s == S_SY) ? YELLOW : s == S_SG ? GREEN_SIDE : GREEN_MAIN;
  endfunction
  assign tick = tick_in & ~tick_d_q;
  always_comb begin
    seq_nx  = state_q[1:0] + 2'd1;
    nxt     = state_e'({1'b0, seq_nx});
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = 1'b0;
    if (emergency) begin
      state_d = S_ALLRED;
      cnt_d   = '0;
    end else if (night_mode) begin
      state_d = S_NIGHT;
      cnt_d   = '0;
      flash_d = (state_q == S_NIGHT) & (flash_q ^ tick);
    end else if (state_q[2]) begin
      state_d = S_MG;
      cnt_d   = GREEN_MAIN;
    end else if (tick) begin
      state_d = cnt_q == 7'd1 ? nxt : state_q;
      cnt_d   = cnt_q == 7'd1 ? dur(nxt) : cnt_q - 7'd1;
    end
  end
  always_ff @(posedge clkin) begin
    tick_d_q <= tick_in;
    if (!rst_N) begin
      state_q <= S_MG;
      cnt_q   <= GREEN_MAIN;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
    end
  end
  assign main_lamp = state_q == S_ALLRED ? LAMP_R :
                     state_q == S_NIGHT  ? {1'b0, flash_q, 1'b0} :
                     state_q == S_MG     ? LAMP_G :
                     state_q == S_MY     ? LAMP_Y : LAMP_R;
  assign side_lamp = state_q == S_ALLRED ? LAMP_R :
                     state_q == S_NIGHT  ? {1'b0, flash_q, 1'b0} :
                     state_q == S_SG     ? LAMP_G :
                     state_q == S_SY     ? LAMP_Y : LAMP_R;
  assign phase = state_q;
  bin2bcd_99 u_bcd (
    .bin(cnt_q),
    .bcd(count_bcd)
  );
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_traffic_light_ctrl;
  logic       clkin = 1'b0;
  logic       rst_N = 1'b0;
  logic       tick_in = 1'b0;
  logic       night_mode = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] main_lamp, side_lamp, phase;
  logic [7:0] count_bcd;
  traffic_light_ctrl #(
    .GREEN_MAIN(7'd5),
    .GREEN_SIDE(7'd3),
    .YELLOW    (7'd2)
  ) dut (
    .clkin     (clkin),
    .rst_N     (rst_N),
    .tick_in   (tick_in),
    .night_mode(night_mode),
    .emergency (emergency),
    .main_lamp (main_lamp),
    .side_lamp (side_lamp),
    .count_bcd (count_bcd),
    .phase     (phase)
  );
  always #5 clkin = ~clkin;
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask
  bit tog_en = 0;
  int tc = 0;
  initial forever begin
    @(posedge clkin);
    #1;
    if (tog_en) begin
      tc++;
      if (tc == 4) begin
        tc = 0;
        tick_in = ~tick_in;
      end
    end
  end
  int         m_mode = 0;
  int         m_idx = 0;
  int         m_rem = 5;
  bit         m_flash = 0;
  bit         m_prev = 0;
  bit         m_valid = 0;
  int         dur[4] = '{5, 2, 3, 2};
  logic [2:0] ml_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] sl_tab[4] = '{3'b100, 3'b100, 3'b001, 3'b010};
  always @(posedge clkin) begin : model
    bit t;
    t = tick_in && !m_prev;
    m_prev = tick_in;
    m_valid = 1;
    if (!rst_N) begin
      m_mode = 0; m_idx = 0; m_rem = 5; m_flash = 0;
    end else if (emergency) begin
      m_mode = 2; m_rem = 0; m_flash = 0;
    end else if (night_mode) begin
      if (m_mode != 1) m_flash = 0;
      else if (t) m_flash = !m_flash;
      m_mode = 1; m_rem = 0;
    end else if (m_mode != 0) begin
      m_mode = 0; m_idx = 0; m_rem = 5; m_flash = 0;
    end else if (t) begin
      if (m_rem == 1) begin
        m_idx = (m_idx + 1) % 4;
        m_rem = dur[m_idx];
      end else m_rem--;
    end
  end
  always @(negedge clkin) begin
    if (m_valid) begin
      check("model_main", main_lamp,
            m_mode == 2 ? 3'b100 : m_mode == 1 ? {1'b0, m_flash, 1'b0} : ml_tab[m_idx]);
      check("model_side", side_lamp,
            m_mode == 2 ? 3'b100 : m_mode == 1 ? {1'b0, m_flash, 1'b0} : sl_tab[m_idx]);
      check("model_bcd", count_bcd, {4'(m_rem / 10), 4'(m_rem % 10)});
      check("model_phase", phase, m_mode == 2 ? 3'd5 : m_mode == 1 ? 3'd4 : 3'(m_idx));
    end
  end
  task automatic wait_for(input logic [2:0] p, input logic [7:0] b);
    int k;
    k = 0;
    while (!(phase == p && (b == 8'hff || count_bcd == b)) && k < 200) begin
      @(negedge clkin);
      k++;
    end
    check("wait_state_reached", k < 200, 1'b1);
  endtask
  task automatic wait_rise();
    int k;
    logic last;
    k = 0;
    last = tick_in;
    @(negedge clkin);
    while (!(tick_in && !last) && k < 40) begin
      last = tick_in;
      @(negedge clkin);
      k++;
    end
    check("wait_tick_rise", k < 40, 1'b1);
  endtask
  logic [7:0] exp_seq[12] = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02,
                              8'h01, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01};
  initial begin
    logic [7:0] seen[12];
    logic [7:0] last;
    logic [2:0] lastl;
    int j, k;
    repeat (3) @(negedge clkin);
    check("rst_main", main_lamp, 3'b001);
    check("rst_side", side_lamp, 3'b100);
    check("rst_bcd", count_bcd, 8'h05);
    check("rst_phase", phase, 3'd0);
    rst_N = 1;
    tog_en = 1;
    seen[0] = count_bcd;
    last = count_bcd;
    j = 1;
    k = 0;
    while (j < 12 && k < 300) begin
      @(negedge clkin);
      k++;
      if (count_bcd != last) begin
        seen[j] = count_bcd;
        last = count_bcd;
        j++;
        if (j == 6) begin
          check("five_ticks_phase", phase, 3'd1);
          check("five_ticks_main", main_lamp, 3'b010);
        end
      end
    end
    check("seq_complete", j == 12, 1'b1);
    for (int i = 0; i < 12; i++) check($sformatf("seq_%0d", i), seen[i], exp_seq[i]);
    k = 0;
    while (count_bcd == last && k < 40) begin
      @(negedge clkin);
      k++;
    end
    check("loop_back_phase", phase, 3'd0);
    check("loop_back_bcd", count_bcd, 8'h05);
    wait_for(3'd2, 8'h02);
    emergency = 1;
    @(negedge clkin);
    check("emer_main", main_lamp, 3'b100);
    check("emer_side", side_lamp, 3'b100);
    check("emer_bcd", count_bcd, 8'h00);
    check("emer_phase", phase, 3'd5);
    repeat (3) @(negedge clkin);
    emergency = 0;
    @(negedge clkin);
    check("emer_exit_phase", phase, 3'd0);
    check("emer_exit_bcd", count_bcd, 8'h05);
    night_mode = 1;
    @(negedge clkin);
    check("night_phase", phase, 3'd4);
    check("night_main_off", main_lamp, 3'b000);
    lastl = main_lamp;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (main_lamp == lastl && k < 40) begin
        @(negedge clkin);
        k++;
      end
      lastl = main_lamp;
      check($sformatf("night_flash_%0d", i), main_lamp, (i % 2 == 0) ? 3'b010 : 3'b000);
      check($sformatf("night_side_%0d", i), side_lamp, (i % 2 == 0) ? 3'b010 : 3'b000);
    end
    night_mode = 0;
    @(negedge clkin);
    check("night_exit_phase", phase, 3'd0);
    check("night_exit_main", main_lamp, 3'b001);
    check("night_exit_bcd", count_bcd, 8'h05);
    wait_rise();
    night_mode = 1;
    @(negedge clkin);
    check("night_coincident_tick", main_lamp, 3'b000);
    emergency = 1;
    @(negedge clkin);
    check("both_phase", phase, 3'd5);
    emergency = 0;
    @(negedge clkin);
    check("emer_drop_to_night", phase, 3'd4);
    check("emer_drop_lamp", main_lamp, 3'b000);
    night_mode = 0;
    @(negedge clkin);
    check("night_drop_phase", phase, 3'd0);
    wait_rise();
    emergency = 1;
    @(negedge clkin);
    check("emer_coincident_phase", phase, 3'd5);
    check("emer_coincident_bcd", count_bcd, 8'h00);
    emergency = 0;
    @(negedge clkin);
    check("emer_coincident_exit", count_bcd, 8'h05);
    wait_for(3'd3, 8'hff);
    rst_N = 0;
    @(negedge clkin);
    check("midrst_main", main_lamp, 3'b001);
    check("midrst_side", side_lamp, 3'b100);
    check("midrst_bcd", count_bcd, 8'h05);
    check("midrst_phase", phase, 3'd0);
    tog_en = 0;
    tick_in = 1;
    @(negedge clkin);
    rst_N = 1;
    repeat (10) @(negedge clkin);
    check("high_at_release_no_tick", count_bcd, 8'h05);
    tick_in = 0;
    repeat (2) @(negedge clkin);
    tick_in = 1;
    @(negedge clkin);
    check("next_rise_ticks", count_bcd, 8'h04);
    repeat (2) @(negedge clkin);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
